// File: rtl/mc_controller.sv
// mc_controller: multicycle control FSM for the RV32I subset core
// (lw, sw, R-type, I-type ALU, beq, jal).
// Sequences the shared memory port, ALU and register file, and waits on the
// single-port memory handshake (mem_ready) in FETCH, MEMREAD and MEMWRITE.
//
// Build option:
//   MC_ILLEGAL_TRAP_EN  - when defined, an illegal opcode parks the FSM in
//                         HALT with the extra 'illegal' output held high
//                         until reset. When undefined, an illegal opcode
//                         retires as a two-cycle nop and 'illegal' is absent.
module mc_controller (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ALUOp,
    output logic [1:0] ImmSrc,
`ifdef MC_ILLEGAL_TRAP_EN
    output logic       illegal,
`endif
    output logic       instr_done
);

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    typedef enum logic [3:0] {
        FETCH    = 4'd0,
        DECODE   = 4'd1,
        MEMADR   = 4'd2,
        MEMREAD  = 4'd3,
        MEMWB    = 4'd4,
        MEMWRITE = 4'd5,
        EXECR    = 4'd6,
        EXECI    = 4'd7,
        ALUWB    = 4'd8,
        BEQ      = 4'd9,
        JAL      = 4'd10,
        HALT     = 4'd11
    } state_t;

    state_t state_q;
    state_t state_d;

    // Decoded (pre-reset-gating) control values.
    logic       mem_req_c;
    logic       pc_write_c;
    logic       adr_src_c;
    logic       mem_write_c;
    logic       ir_write_c;
    logic       reg_write_c;
    logic [1:0] result_src_c;
    logic [1:0] alu_src_a_c;
    logic [1:0] alu_src_b_c;
    logic [1:0] alu_op_c;
    logic [1:0] imm_src_c;
    logic       instr_done_c;
    logic       illegal_c;
    logic       imm_valid_c;

    // State register, reset to FETCH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and control decode from state, op, zero and mem_ready.
    always_comb begin
        state_d      = state_q;
        mem_req_c    = 1'b0;
        pc_write_c   = 1'b0;
        adr_src_c    = 1'b0;
        mem_write_c  = 1'b0;
        ir_write_c   = 1'b0;
        reg_write_c  = 1'b0;
        result_src_c = 2'b00;
        alu_src_a_c  = 2'b00;
        alu_src_b_c  = 2'b00;
        alu_op_c     = 2'b00;
        instr_done_c = 1'b0;
        illegal_c    = 1'b0;
        imm_valid_c  = 1'b1;

        case (state_q)
            FETCH: begin
                mem_req_c    = 1'b1;
                adr_src_c    = 1'b0;
                alu_src_b_c  = 2'b10;
                result_src_c = 2'b10;
                if (mem_ready) begin
                    ir_write_c = 1'b1;
                    pc_write_c = 1'b1;
                    state_d    = DECODE;
                end
            end

            DECODE: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b01;
                case (op)
                    OP_LOAD,
                    OP_STORE: state_d = MEMADR;
                    OP_RTYPE: state_d = EXECR;
                    OP_ITYPE: state_d = EXECI;
                    OP_BEQ:   state_d = BEQ;
                    OP_JAL:   state_d = JAL;
                    default: begin
`ifdef MC_ILLEGAL_TRAP_EN
                        state_d = HALT;
`else
                        instr_done_c = 1'b1;
                        state_d      = FETCH;
`endif
                    end
                endcase
            end

            MEMADR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                state_d     = (op == OP_LOAD) ? MEMREAD : MEMWRITE;
            end

            MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src_c = 1'b1;
                if (mem_ready) begin
                    state_d = MEMWB;
                end
            end

            MEMWB: begin
                result_src_c = 2'b01;
                reg_write_c  = 1'b1;
                instr_done_c = 1'b1;
                state_d      = FETCH;
            end

            MEMWRITE: begin
                mem_req_c   = 1'b1;
                adr_src_c   = 1'b1;
                mem_write_c = 1'b1;
                if (mem_ready) begin
                    instr_done_c = 1'b1;
                    state_d      = FETCH;
                end
            end

            EXECR: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b00;
                alu_op_c    = 2'b10;
                state_d     = ALUWB;
            end

            EXECI: begin
                alu_src_a_c = 2'b10;
                alu_src_b_c = 2'b01;
                alu_op_c    = 2'b10;
                state_d     = ALUWB;
            end

            ALUWB: begin
                reg_write_c  = 1'b1;
                result_src_c = 2'b00;
                instr_done_c = 1'b1;
                state_d      = FETCH;
            end

            BEQ: begin
                alu_src_a_c  = 2'b10;
                alu_src_b_c  = 2'b00;
                alu_op_c     = 2'b01;
                pc_write_c   = zero;
                instr_done_c = 1'b1;
                state_d      = FETCH;
            end

            JAL: begin
                alu_src_a_c = 2'b01;
                alu_src_b_c = 2'b10;
                pc_write_c  = 1'b1;
                state_d     = ALUWB;
            end

`ifdef MC_ILLEGAL_TRAP_EN
            HALT: begin
                illegal_c   = 1'b1;
                imm_valid_c = 1'b0;
                state_d     = HALT;
            end
`endif

            default: begin
                imm_valid_c = 1'b0;
                state_d     = FETCH;
            end
        endcase
    end

    // Immediate format select from op, forced low in HALT / unused encodings.
    always_comb begin
        imm_src_c = 2'b00;
        if (imm_valid_c) begin
            case (op)
                OP_STORE: imm_src_c = 2'b01;
                OP_BEQ:   imm_src_c = 2'b10;
                OP_JAL:   imm_src_c = 2'b11;
                default:  imm_src_c = 2'b00;
            endcase
        end
    end

    // Output drive; reset gating makes every output 0 while rst_n is low.
    always_comb begin
        mem_req    = mem_req_c    & rst_n;
        PCWrite    = pc_write_c   & rst_n;
        AdrSrc     = adr_src_c    & rst_n;
        MemWrite   = mem_write_c  & rst_n;
        IRWrite    = ir_write_c   & rst_n;
        RegWrite   = reg_write_c  & rst_n;
        ResultSrc  = result_src_c & {2{rst_n}};
        ALUSrcA    = alu_src_a_c  & {2{rst_n}};
        ALUSrcB    = alu_src_b_c  & {2{rst_n}};
        ALUOp      = alu_op_c     & {2{rst_n}};
        ImmSrc     = imm_src_c    & {2{rst_n}};
        instr_done = instr_done_c & rst_n;
`ifdef MC_ILLEGAL_TRAP_EN
        illegal    = illegal_c    & rst_n;
`endif
    end

`ifndef MC_ILLEGAL_TRAP_EN
    // illegal_c is only consumed by the trap build.
    logic unused_ok;
    always_comb begin
        unused_ok = illegal_c;
    end
`endif

endmodule

// File: tb/tb_mc_controller.sv
// Self-checking bench for mc_controller: a table of per-cycle vectors
// {rst_n, op, zero, mem_ready, expected outputs} applied in order, plus
// hand-written sequences for async reset, cycle counts and illegal ops.
module tb_mc_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic       zero;
    logic       mem_ready;
    logic       mem_req;
    logic       PCWrite;
    logic       AdrSrc;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ALUOp;
    logic [1:0] ImmSrc;
    logic       instr_done;
`ifdef MC_ILLEGAL_TRAP_EN
    logic       illegal;
`endif

    int checks;
    int errors;

    mc_controller dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .PCWrite    (PCWrite),
        .AdrSrc     (AdrSrc),
        .MemWrite   (MemWrite),
        .IRWrite    (IRWrite),
        .RegWrite   (RegWrite),
        .ResultSrc  (ResultSrc),
        .ALUSrcA    (ALUSrcA),
        .ALUSrcB    (ALUSrcB),
        .ALUOp      (ALUOp),
        .ImmSrc     (ImmSrc),
`ifdef MC_ILLEGAL_TRAP_EN
        .illegal    (illegal),
`endif
        .instr_done (instr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        rst_n;
        logic [6:0]  op;
        logic        zero;
        logic        rdy;
        logic [16:0] exp;
    } vec_t;

    vec_t vq[$];

    // Packing order: mem_req PCWrite AdrSrc MemWrite IRWrite RegWrite
    //                ResultSrc ALUSrcA ALUSrcB ALUOp ImmSrc instr_done
    function automatic logic [16:0] mk(input logic mr, input logic pw, input logic ad,
                                       input logic mw, input logic iw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] ao,
                                       input logic [1:0] im, input logic dn);
        return {mr, pw, ad, mw, iw, rw, rs, sa, sb, ao, im, dn};
    endfunction

    function automatic logic [16:0] act();
        return {mem_req, PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite,
                ResultSrc, ALUSrcA, ALUSrcB, ALUOp, ImmSrc, instr_done};
    endfunction

    task automatic add(input string n, input logic r, input logic [6:0] o,
                       input logic z, input logic y, input logic [16:0] e);
        vec_t v;
        v.name = n; v.rst_n = r; v.op = o; v.zero = z; v.rdy = y; v.exp = e;
        vq.push_back(v);
    endtask

    task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", n, a, e);
        end
    endtask

    // Run one instruction from FETCH with mem_ready=1, counting cycles to instr_done.
    task automatic count_instr(input string n, input logic [6:0] o, input int exp_cycles);
        int cyc;
        cyc = 0;
        do begin
            @(negedge clk);
            op = o; zero = 1'b0; mem_ready = 1'b1;
            #1;
            cyc++;
        end while (instr_done !== 1'b1 && cyc < 40);
        chk(n, cyc, exp_cycles);
    endtask

    localparam logic [6:0] R  = 7'b0110011;
    localparam logic [6:0] I  = 7'b0010011;
    localparam logic [6:0] LW = 7'b0000011;
    localparam logic [6:0] SW = 7'b0100011;
    localparam logic [6:0] BQ = 7'b1100011;
    localparam logic [6:0] JL = 7'b1101111;
    localparam logic [6:0] IL = 7'b1111111;

    initial begin
        checks = 0; errors = 0;
        rst_n = 1'b0; op = R; zero = 1'b0; mem_ready = 1'b1;

        // Reset held 3 cycles
        add("rst0", 0, R, 0, 1, '0);
        add("rst1", 0, R, 0, 1, '0);
        add("rst2", 0, R, 1, 1, '0);
        // add
        add("add_fetch",  1, R, 0, 1, mk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
        add("add_decode", 1, R, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0));
        add("add_execr",  1, R, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b10,2'b00,0));
        add("add_aluwb",  1, R, 0, 1, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,1));
        // lw with two wait cycles in MEMREAD
        add("lw_fetch",   1, LW, 0, 1, mk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
        add("lw_decode",  1, LW, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0));
        add("lw_memadr",  1, LW, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b00,0));
        add("lw_rd_w0",   1, LW, 0, 0, mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0));
        add("lw_rd_w1",   1, LW, 0, 0, mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0));
        add("lw_rd_ok",   1, LW, 0, 1, mk(1,0,1,0,0,0,2'b00,2'b00,2'b00,2'b00,2'b00,0));
        add("lw_memwb",   1, LW, 0, 1, mk(0,0,0,0,0,1,2'b01,2'b00,2'b00,2'b00,2'b00,1));
        // beq taken (zero ignored in FETCH)
        add("beq1_fetch", 1, BQ, 1, 1, mk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b10,0));
        add("beq1_dec",   1, BQ, 1, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0));
        add("beq1_exec",  1, BQ, 1, 1, mk(0,1,0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,1));
        // beq not taken; mem_ready low outside memory states is ignored
        add("beq0_fetch", 1, BQ, 0, 1, mk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b10,0));
        add("beq0_dec",   1, BQ, 0, 0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b10,0));
        add("beq0_exec",  1, BQ, 0, 0, mk(0,0,0,0,0,0,2'b00,2'b10,2'b00,2'b01,2'b10,1));
        // sw with one FETCH wait and three MEMWRITE waits
        add("sw_fetch_w", 1, SW, 0, 0, mk(1,0,0,0,0,0,2'b10,2'b00,2'b10,2'b00,2'b01,0));
        add("sw_fetch",   1, SW, 0, 1, mk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b01,0));
        add("sw_decode",  1, SW, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b01,0));
        add("sw_memadr",  1, SW, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b00,2'b01,0));
        add("sw_wr_w0",   1, SW, 0, 0, mk(1,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b01,0));
        add("sw_wr_w1",   1, SW, 0, 0, mk(1,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b01,0));
        add("sw_wr_w2",   1, SW, 0, 0, mk(1,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b01,0));
        add("sw_wr_ok",   1, SW, 0, 1, mk(1,0,1,1,0,0,2'b00,2'b00,2'b00,2'b00,2'b01,1));
        // jal
        add("jal_fetch",  1, JL, 0, 1, mk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b11,0));
        add("jal_decode", 1, JL, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b11,0));
        add("jal_jal",    1, JL, 0, 1, mk(0,1,0,0,0,0,2'b00,2'b01,2'b10,2'b00,2'b11,0));
        add("jal_aluwb",  1, JL, 0, 1, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b11,1));
        // addi, interrupted by reset after DECODE
        add("addi_fetch", 1, I, 0, 1, mk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
        add("addi_dec",   1, I, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0));
        add("addi_rst",   0, I, 0, 1, '0);
        add("addi_refet", 1, I, 0, 1, mk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0));
        add("addi_dec2",  1, I, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0));
        add("addi_execi", 1, I, 0, 1, mk(0,0,0,0,0,0,2'b00,2'b10,2'b01,2'b10,2'b00,0));
        add("addi_aluwb", 1, I, 0, 1, mk(0,0,0,0,0,1,2'b00,2'b00,2'b00,2'b00,2'b00,1));

        foreach (vq[i]) begin
            @(negedge clk);
            rst_n = vq[i].rst_n; op = vq[i].op; zero = vq[i].zero; mem_ready = vq[i].rdy;
            #1;
            chk(vq[i].name, {15'd0, act()}, {15'd0, vq[i].exp});
        end

        // Asynchronous reset mid-cycle in EXECR drops outputs immediately
        @(negedge clk); op = R; mem_ready = 1'b1; // FETCH
        @(negedge clk);                           // DECODE
        @(negedge clk); #1;                       // EXECR
        chk("async_pre_aluop", {30'd0, ALUOp}, 32'd2);
        @(posedge clk); #2;
        @(negedge clk); #2;                       // ALUWB, mid-low-phase
        rst_n = 1'b0; #1;
        chk("async_rst_zero", {15'd0, act()}, 32'd0);
        @(negedge clk); rst_n = 1'b1; #1;
        chk("async_refetch", {15'd0, act()},
            {15'd0, mk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0)});

        // Instruction length with zero wait (starting from FETCH)
        @(negedge clk); // leave FETCH -> DECODE; finish this add
        @(negedge clk);
        @(negedge clk); // ALUWB done, next is FETCH
        count_instr("cyc_beq",  BQ, 3);
        count_instr("cyc_add",  R,  4);
        count_instr("cyc_addi", I,  4);
        count_instr("cyc_sw",   SW, 4);
        count_instr("cyc_jal",  JL, 4);
        count_instr("cyc_lw",   LW, 5);

        // Illegal opcode
        @(negedge clk); op = IL; zero = 1'b0; mem_ready = 1'b1; #1;
        chk("ill_fetch", {15'd0, act()},
            {15'd0, mk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0)});
        @(negedge clk); #1;
`ifdef MC_ILLEGAL_TRAP_EN
        chk("ill_decode", {15'd0, act()},
            {15'd0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,0)});
        for (int k = 0; k < 20; k++) begin
            @(negedge clk); mem_ready = k[0]; op = (k < 10) ? IL : R; #1;
            chk("halt_hold", {14'd0, illegal, act()}, {14'd0, 1'b1, 17'd0});
        end
        @(negedge clk); rst_n = 1'b0; #1;
        chk("halt_rst", {14'd0, illegal, act()}, 32'd0);
        @(negedge clk); rst_n = 1'b1; op = R; #1;
        chk("halt_refetch", {14'd0, illegal, act()},
            {14'd0, 1'b0, mk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0)});
`else
        chk("ill_decode", {15'd0, act()},
            {15'd0, mk(0,0,0,0,0,0,2'b00,2'b01,2'b01,2'b00,2'b00,1)});
        @(negedge clk); op = R; #1;
        chk("ill_refetch", {15'd0, act()},
            {15'd0, mk(1,1,0,0,1,0,2'b10,2'b00,2'b10,2'b00,2'b00,0)});
        count_instr("cyc_illegal", IL, 0 + 1);
        count_instr("cyc_illegal2", IL, 2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
